// File: rtl/hhmm_counter.sv
// Hours:minutes BCD time counter advanced only by single-cycle increment pulses.
// Latency: digits and day_tick are registered; a pulse is visible one cycle later.
// Backpressure: none; every sampled pulse is consumed on that edge.
//
// Ports:
//   ck        system clock, all state on rising edge
//   reset     synchronous active-high reset, loads INIT_HOUR:INIT_MIN
//   up60      minute-advance pulse (held high N cycles = N increments)
//   up_hh     hour-advance pulse
//   nocarry   1 = minute wrap 59->00 leaves hours alone (set mode)
//   min_u/min_t, hour_u/hour_t   BCD digits
//   day_tick  one-cycle pulse when the hour wraps past midnight
//   pm        (H12_MODE_EN only) afternoon flag for 12-hour display
//
// Build option: define H12_MODE_EN for 12-hour counting (12,01..11 plus pm).
module hhmm_counter #(
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       up60,
    input  logic       up_hh,
    input  logic       nocarry,
    output logic [3:0] min_u,
    output logic [2:0] min_t,
    output logic [3:0] hour_u,
    output logic [1:0] hour_t,
`ifdef H12_MODE_EN
    output logic       pm,
`endif
    output logic       day_tick
);

    // INIT_HOUR is always given on a 24h scale; in 12h mode it is folded
    // onto 12,01..11 with a separate pm flag.
`ifdef H12_MODE_EN
    localparam int   INIT_HDISP = ((INIT_HOUR % 12) == 0) ? 12 : (INIT_HOUR % 12);
    localparam logic RST_PM     = (INIT_HOUR >= 12);
    localparam logic [1:0] ZERO_HT = 2'd1;   // 12 AM is the "zero" hour
    localparam logic [3:0] ZERO_HU = 4'd2;
`else
    localparam int   INIT_HDISP = INIT_HOUR;
    localparam logic [1:0] ZERO_HT = 2'd0;
    localparam logic [3:0] ZERO_HU = 4'd0;
`endif
    localparam logic [1:0] RST_HT = 2'(INIT_HDISP / 10);
    localparam logic [3:0] RST_HU = 4'(INIT_HDISP % 10);
    localparam logic [2:0] RST_MT = 3'(INIT_MIN / 10);
    localparam logic [3:0] RST_MU = 4'(INIT_MIN % 10);

    // Hour position plus a sticky flag recording a midnight crossing, so a
    // two-step advance can report a wrap that happened on either step.
    typedef struct packed {
        logic [1:0] t;
        logic [3:0] u;
`ifdef H12_MODE_EN
        logic       pm;
`endif
        logic       wrap;
    } hpos_t;

    function automatic hpos_t hour_inc(input hpos_t h);
        hpos_t n;
        n = h;
`ifdef H12_MODE_EN
        if (h.t == 2'd1 && h.u == 4'd1) begin
            // 11 -> 12 flips AM/PM; leaving 11 PM is the day boundary.
            n.t    = 2'd1;
            n.u    = 4'd2;
            n.pm   = ~h.pm;
            n.wrap = h.wrap | h.pm;
        end else if (h.t == 2'd1 && h.u == 4'd2) begin
            n.t = 2'd0;
            n.u = 4'd1;
        end
`else
        // Wrap is decoded on the BCD pair 2,3, not on units reaching 9.
        if (h.t == 2'd2 && h.u == 4'd3) begin
            n.t    = 2'd0;
            n.u    = 4'd0;
            n.wrap = 1'b1;
        end
`endif
        else if (h.u == 4'd9) begin
            n.t = h.t + 2'd1;
            n.u = 4'd0;
        end else begin
            n.u = h.u + 4'd1;
        end
        return n;
    endfunction

    logic [3:0] min_u_q, min_u_d;
    logic [2:0] min_t_q, min_t_d;
    logic [3:0] hour_u_q;
    logic [1:0] hour_t_q;
    logic       day_tick_q;
    logic       mc;
    logic       hour_bad;
    hpos_t      h_cur, h_one, h_two, h_nxt;
`ifdef H12_MODE_EN
    logic       pm_q;
`endif

    // Minutes: cascaded BCD units/tens; illegal values recover to 00 silently.
    always_comb begin
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        mc      = 1'b0;
        if (min_u_q > 4'd9 || min_t_q > 3'd5) begin
            min_u_d = 4'd0;
            min_t_d = 3'd0;
        end else if (up60) begin
            if (min_u_q == 4'd9) begin
                min_u_d = 4'd0;
                if (min_t_q == 3'd5) begin
                    min_t_d = 3'd0;
                    mc      = ~nocarry;
                end else begin
                    min_t_d = min_t_q + 3'd1;
                end
            end else begin
                min_u_d = min_u_q + 4'd1;
            end
        end
    end

    // Hours: step of up_hh + mc (0..2) built from chained single increments.
    always_comb begin
        h_cur.t    = hour_t_q;
        h_cur.u    = hour_u_q;
`ifdef H12_MODE_EN
        h_cur.pm   = pm_q;
        hour_bad   = (hour_t_q > 2'd1) || (hour_u_q > 4'd9) ||
                     (hour_t_q == 2'd1 && hour_u_q > 4'd2) ||
                     (hour_t_q == 2'd0 && hour_u_q == 4'd0);
`else
        hour_bad   = (hour_t_q > 2'd2) || (hour_u_q > 4'd9) ||
                     (hour_t_q == 2'd2 && hour_u_q > 4'd3);
`endif
        h_cur.wrap = 1'b0;
        h_one      = hour_inc(h_cur);
        h_two      = hour_inc(h_one);
        h_nxt      = h_cur;
        if (hour_bad) begin
            h_nxt.t    = ZERO_HT;
            h_nxt.u    = ZERO_HU;
`ifdef H12_MODE_EN
            h_nxt.pm   = 1'b0;
`endif
            h_nxt.wrap = 1'b0;
        end else if (up_hh && mc) begin
            h_nxt = h_two;
        end else if (up_hh || mc) begin
            h_nxt = h_one;
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            min_u_q    <= RST_MU;
            min_t_q    <= RST_MT;
            hour_u_q   <= RST_HU;
            hour_t_q   <= RST_HT;
            day_tick_q <= 1'b0;
`ifdef H12_MODE_EN
            pm_q       <= RST_PM;
`endif
        end else begin
            min_u_q    <= min_u_d;
            min_t_q    <= min_t_d;
            hour_u_q   <= h_nxt.u;
            hour_t_q   <= h_nxt.t;
            day_tick_q <= h_nxt.wrap;
`ifdef H12_MODE_EN
            pm_q       <= h_nxt.pm;
`endif
        end
    end

    assign min_u    = min_u_q;
    assign min_t    = min_t_q;
    assign hour_u   = hour_u_q;
    assign hour_t   = hour_t_q;
    assign day_tick = day_tick_q;
`ifdef H12_MODE_EN
    assign pm       = pm_q;
`endif

endmodule
